// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes AND/OR/ADD/SUB/SLT with flags and hands results
// downstream through a two-entry skid buffer (output register + skid register),
// giving 1 op/cycle with a fully registered in_ready.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
  } entry_t;

  entry_t           new_entry;
  entry_t           o_q, o_d, s_q, s_d;
  logic             o_valid_q, o_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sum, diff, res;
  logic             add_ovf, sub_ovf, slt_lt;
  logic             push, pop;

  // Datapath: result and flags for the operation currently presented
  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    // Signed less-than: subtract sign corrected by subtract overflow
    slt_lt  = diff[WIDTH-1] ^ sub_ovf;
    res                = '0;
    new_entry.overflow = 1'b0;
    new_entry.illegal  = 1'b0;
    case (alu_ctrl)
      CTRL_AND: res = op_a & op_b;
      CTRL_OR:  res = op_a | op_b;
      CTRL_ADD: begin
        res                = sum;
        new_entry.overflow = add_ovf;
      end
      CTRL_SUB: begin
        res                = diff;
        new_entry.overflow = sub_ovf;
      end
      CTRL_SLT: res = {{(WIDTH-1){1'b0}}, slt_lt};
      default:  new_entry.illegal = 1'b1;
    endcase
    new_entry.result = res;
    new_entry.zero   = (res == '0);
  end

  assign push = in_valid && in_ready_q;
  assign pop  = o_valid_q && out_ready;

  // Next state of the output/skid registers; first matching rule wins
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (s_valid_q && pop) begin
      o_d       = s_q;
      s_valid_d = 1'b0;
    end else if (!s_valid_q && push && (!o_valid_q || pop)) begin
      o_d       = new_entry;
      o_valid_d = 1'b1;
    end else if (!s_valid_q && push) begin
      s_d       = new_entry;
      s_valid_d = 1'b1;
    end else if (!s_valid_q && pop) begin
      o_valid_d = 1'b0;
    end
    in_ready_d = !s_valid_d;
  end

  // State registers with synchronous reset; reset drops any buffered entries
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q        <= '0;
      s_q        <= '0;
      o_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      o_q        <= o_d;
      s_q        <= s_d;
      o_valid_q  <= o_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = o_valid_q;
  assign result    = o_q.result;
  assign zero      = o_q.zero;
  assign overflow  = o_q.overflow;
  assign illegal   = o_q.illegal;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered ALU execute stage sitting directly downstream of the ALU-control decoder; consumes its 3-bit control code plus two operands.
- Produces result, zero, overflow and illegal-code flags.
- Valid/ready handshake on both sides with a 2-entry skid buffer: full throughput of 1 op/cycle, no combinational ready path from out_ready to in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  stage can accept; registered, equals !skid_valid and is 0 while rst is high.
- alu_ctrl  input  3  decoder code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; 011/100/101 illegal.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer accepts.
- result  output  WIDTH  computed value.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal  output  1  alu_ctrl was an illegal code.

Behaviour:
- Reset (rst high at a clk edge): out_valid=0, skid_valid=0, result=0, zero=0, overflow=0, illegal=0. in_ready=1 from the first edge with rst low. Reset mid-operation discards both entries; no partial output.
- Arithmetic:
  - AND/OR: bitwise.
  - ADD: a+b mod 2^WIDTH; overflow = sign(a)==sign(b) && sign(sum)!=sign(a).
  - SUB: a-b mod 2^WIDTH; overflow = sign(a)!=sign(b) && sign(diff)!=sign(a).
  - SLT: result = 1 if a<b signed, else 0. Use the overflow-corrected subtract sign. overflow reported 0.
  - Illegal code: result=0, zero=1, illegal=1, overflow=0.
  - zero is computed on the final result for every code.
- All result fields are computed combinationally from the inputs and captured together as one entry {result, zero, overflow, illegal}.
- Handshake: push = in_valid && in_ready; pop = out_valid && out_ready. Inputs are sampled only on push. out_* fields are stable while out_valid && !out_ready.
- Storage: output register O (drives outputs) and skid register S. Per-edge rules, first matching rule wins:
  1. S valid && pop: O<=S, S_valid<=0. push is impossible in this case since in_ready=0.
  2. S empty && push && (!O_valid || pop): O<=new, O_valid<=1.
  3. S empty && push && O_valid && !pop: S<=new, S_valid<=1.
  4. S empty && !push && pop: O_valid<=0.
  5. Otherwise: hold.
- Latency: 1 cycle accept-to-out_valid when empty. Sustained 1 op/cycle while out_ready=1.
- Full: both O and S valid, so in_ready=0. in_ready returns to 1 the edge after the pop that drains S.
- Order is strictly FIFO. No entry is dropped or duplicated.
- Holding field values when empty is don't-care, except after reset (all 0).

Test Plan:
- Reset then single ops with out_ready=1:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
  - SUB 5-5 -> result 0, zero=1, overflow=0.
  - AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
  - OR 0x00FF0000 | 0x000000FF -> 0x00FF00FF.
- SLT corner cases:
  - a=0x80000000, b=1 -> 1 (overflow-corrected).
  - a=1, b=0xFFFFFFFF -> 0.
  - a=b=3 -> 0, zero=1.
- Illegal code: alu_ctrl=100, a=b=7 -> result 0, zero=1, illegal=1.
- Backpressure:
  - Hold out_ready=0 and push ADD 1+1 then ADD 2+2 -> in_ready drops to 0 after the second accept, and a third in_valid is not accepted.
  - Release out_ready -> outputs 2 then 4 on consecutive cycles; in_ready=1 the edge after the first pop.
- Streaming: 20 back-to-back random ops, out_ready=1 continuously -> one result per cycle, in order, matching a reference model; then random out_ready toggling -> no loss or duplication.
- Reset mid-operation: fill both entries with out_ready=0, assert rst one cycle -> out_valid=0, result=0, in_ready=0 during reset and 1 after. The previously held results never appear.
